// File: rtl/fp_pkg.sv
// Shared single-precision types and constants for the FIR floating-point datapath.
package fp_pkg;

  typedef struct packed {
    logic        sign;
    logic [7:0]  exp;
    logic [22:0] frac;
  } fp32_t;

  localparam int          FP_BIAS    = 127;
  localparam int          FP_EXP_MAX = 255;
  localparam logic [31:0] FP_QNAN    = 32'h7FC00000;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    UNPACK = 3'd1,
    MULT   = 3'd2,
    NORM   = 3'd3,
    PACK   = 3'd4
  } state_t;

endpackage

// File: rtl/multiplier_fp_if.sv
// Start/ready/busy handshake and operand/result bus of the FP multiplier.
interface multiplier_fp_if
  import fp_pkg::*;
;
  logic  start;
  fp32_t A;
  fp32_t B;
  logic  ready;
  logic  busy;
  fp32_t Y;

  modport master (output start, A, B, input ready, busy, Y);
  modport slave  (input start, A, B, output ready, busy, Y);
endinterface

// File: rtl/fp_classify.sv
// Classifies one single-precision operand; subnormals are reported as zero.
module fp_classify
  import fp_pkg::*;
(
  input  fp32_t x_i,
  output logic  zero_o,
  output logic  inf_o,
  output logic  nan_o
);
  logic exp_max;

  assign exp_max = (x_i.exp == 8'(FP_EXP_MAX));
  assign zero_o  = (x_i.exp == 8'h00);
  assign inf_o   = exp_max && (x_i.frac == 23'd0);
  assign nan_o   = exp_max && (x_i.frac != 23'd0);
endmodule

// File: rtl/multiplier_fp.sv
// Multi-cycle IEEE-754 single-precision multiplier (IDLE/UNPACK/MULT/NORM/PACK).
// Optional macro FP_MUL_RNE_EN: round to nearest even; otherwise truncate.
module multiplier_fp
  import fp_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  multiplier_fp_if.slave  bus
);
  state_t             state_q, state_d;
  fp32_t              a_q, b_q;
  logic               sgn_q;
  logic [7:0]         ea_q, eb_q;
  logic [23:0]        ma_q, mb_q;
  logic               nan_q, inf_q, zero_q;
  logic [47:0]        prod_q;
  logic signed [9:0]  exp_q, nexp_q, exp_d;
  logic [22:0]        frac_q, frac_d;
  logic               ready_q;
  logic [31:0]        y_q, y_d;
  logic               za, ia, na, zb, ib, nb;
  logic [22:0]        mant;
  logic signed [9:0]  norm_exp;
`ifdef FP_MUL_RNE_EN
  logic               guard, sticky;
  logic [23:0]        rnd;
`endif

  fp_classify u_cls_a (.x_i(a_q), .zero_o(za), .inf_o(ia), .nan_o(na));
  fp_classify u_cls_b (.x_i(b_q), .zero_o(zb), .inf_o(ib), .nan_o(nb));

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next state: fixed walk through the stages once started
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (bus.start) state_d = UNPACK;
      UNPACK:  state_d = MULT;
      MULT:    state_d = NORM;
      NORM:    state_d = PACK;
      PACK:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs derived from state
  always_comb begin
    bus.busy = (state_q != IDLE);
  end

  // Datapath registers, each stage loads only in its own state
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_q    <= '0;
      b_q    <= '0;
      sgn_q  <= 1'b0;
      ea_q   <= '0;
      eb_q   <= '0;
      ma_q   <= '0;
      mb_q   <= '0;
      nan_q  <= 1'b0;
      inf_q  <= 1'b0;
      zero_q <= 1'b0;
      prod_q <= '0;
      exp_q  <= '0;
      nexp_q <= '0;
      frac_q <= '0;
    end else begin
      case (state_q)
        IDLE: if (bus.start) begin
          a_q <= bus.A;
          b_q <= bus.B;
        end
        UNPACK: begin
          ea_q   <= a_q.exp;
          eb_q   <= b_q.exp;
          ma_q   <= {1'b1, a_q.frac};
          mb_q   <= {1'b1, b_q.frac};
          // inf x zero is invalid and folds into the NaN path
          nan_q  <= na | nb | (ia & zb) | (za & ib);
          inf_q  <= ia | ib;
          zero_q <= za | zb;
        end
        MULT: begin
          sgn_q  <= a_q.sign ^ b_q.sign;
          prod_q <= 48'(ma_q) * 48'(mb_q);
          exp_q  <= 10'({2'b00, ea_q}) + 10'({2'b00, eb_q}) - 10'(FP_BIAS);
        end
        NORM: begin
          frac_q <= frac_d;
          nexp_q <= exp_d;
        end
        default: ;
      endcase
    end
  end

  // Normalise the product (leading 1 at bit 47 or 46) and optionally round
  always_comb begin
    mant     = prod_q[45:23];
    norm_exp = exp_q;
    if (prod_q[47]) begin
      mant     = prod_q[46:24];
      norm_exp = exp_q + 10'sd1;
    end
`ifdef FP_MUL_RNE_EN
    guard  = prod_q[47] ? prod_q[23] : prod_q[22];
    sticky = prod_q[47] ? (|prod_q[22:0]) : (|prod_q[21:0]);
    rnd    = {1'b0, mant} + 24'(guard & (sticky | mant[0]));
    frac_d = rnd[22:0];
    // carry out of the fraction means 1.111.. rounded up to 10.000..
    exp_d  = rnd[23] ? (norm_exp + 10'sd1) : norm_exp;
`else
    frac_d = mant;
    exp_d  = norm_exp;
`endif
  end

  // Result packing with special-case priority
  always_comb begin
    if (nan_q)                   y_d = FP_QNAN;
    else if (inf_q)              y_d = {sgn_q, 8'hFF, 23'd0};
    else if (zero_q)             y_d = {sgn_q, 8'h00, 23'd0};
    else if (nexp_q >= 10'sd255) y_d = {sgn_q, 8'hFF, 23'd0};
    else if (nexp_q <= 10'sd0)   y_d = {sgn_q, 8'h00, 23'd0};
    else                         y_d = {sgn_q, nexp_q[7:0], frac_q};
  end

  // Result register and one-cycle ready pulse on leaving PACK
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ready_q <= 1'b0;
      y_q     <= '0;
    end else begin
      ready_q <= (state_q == PACK);
      if (state_q == PACK) y_q <= y_d;
    end
  end

  assign bus.ready = ready_q;
  assign bus.Y     = y_q;
endmodule

// File: tb/tb_multiplier_fp.sv
// Directed-vector bench for multiplier_fp: table of products plus handshake corner sequences.
module tb_multiplier_fp;
  import fp_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   nvec = 0;
  int   nerr = 0;

  multiplier_fp_if bus();

  multiplier_fp dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] y;
  } vec_t;

  vec_t vecs[12];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Issue one op, sampling 1ns after each edge; returns result, latency and busy flag.
  task automatic do_op(input logic [31:0] a, input logic [31:0] b,
                       output logic [31:0] y, output int lat, output bit busy_ok);
    @(negedge clk);
    bus.start = 1'b1;
    bus.A     = a;
    bus.B     = b;
    @(posedge clk); #1;
    bus.start = 1'b0;
    lat     = 0;
    busy_ok = 1'b1;
    while (bus.ready !== 1'b1 && lat < 20) begin
      if (bus.busy !== 1'b1) busy_ok = 1'b0;
      @(posedge clk); #1;
      lat++;
    end
    if (bus.busy !== 1'b0) busy_ok = 1'b0;
    y = bus.Y;
  endtask

  initial begin
    logic [31:0] y;
    int          lat;
    bit          bok;
    bit          saw_rdy;

    vecs[0]  = '{32'h40000000, 32'h40400000, 32'h40C00000};
    vecs[1]  = '{32'hBFC00000, 32'h40200000, 32'hC0700000};
    vecs[2]  = '{32'h80000000, 32'h40000000, 32'h80000000};
    vecs[3]  = '{32'h7F800000, 32'h00000000, 32'h7FC00000};
    vecs[4]  = '{32'h7F800000, 32'hC0000000, 32'hFF800000};
    vecs[5]  = '{32'h7FC00001, 32'h3F800000, 32'h7FC00000};
    vecs[6]  = '{32'h7F000000, 32'h7F000000, 32'h7F800000};
    vecs[7]  = '{32'h00800000, 32'h00800000, 32'h00000000};
    vecs[8]  = '{32'h00000001, 32'h40000000, 32'h00000000};
`ifdef FP_MUL_RNE_EN
    vecs[9]  = '{32'h3FC00001, 32'h3FC00001, 32'h40100002};
`else
    vecs[9]  = '{32'h3FC00001, 32'h3FC00001, 32'h40100001};
`endif
    vecs[10] = '{32'h3F800000, 32'hBF800000, 32'hBF800000};
    vecs[11] = '{32'hFF800000, 32'h7FC00000, 32'h7FC00000};

    bus.start = 1'b0;
    bus.A     = '0;
    bus.B     = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_ready", 32'(bus.ready), 32'd0);
    chk("reset_busy",  32'(bus.busy),  32'd0);
    chk("reset_Y",     bus.Y,          32'd0);
    @(negedge clk);
    rst = 1'b0;

    // Table vectors, issued back-to-back (start lands in the ready cycle)
    for (int i = 0; i < 12; i++) begin
      do_op(vecs[i].a, vecs[i].b, y, lat, bok);
      chk($sformatf("vec%0d_Y", i),       y,           vecs[i].y);
      chk($sformatf("vec%0d_latency", i), 32'(lat),    32'd4);
      chk($sformatf("vec%0d_busy", i),    32'(bok),    32'd1);
    end

    // Ready is a single-cycle pulse and Y holds afterwards
    repeat (3) begin
      @(posedge clk); #1;
      chk("ready_drop", 32'(bus.ready), 32'd0);
      chk("Y_hold",     bus.Y,          vecs[11].y);
    end

    // start during busy with different operands is ignored
    @(negedge clk);
    bus.start = 1'b1;
    bus.A = 32'h40000000;
    bus.B = 32'h40400000;
    @(posedge clk); #1;
    bus.A = 32'h3F800000;
    bus.B = 32'h3F800000;
    lat = 0;
    while (bus.ready !== 1'b1 && lat < 20) begin
      if (lat == 2) bus.start = 1'b0;
      @(posedge clk); #1;
      lat++;
    end
    bus.start = 1'b0;
    chk("ignore_start_Y",   bus.Y,    32'h40C00000);
    chk("ignore_start_lat", 32'(lat), 32'd4);
    @(posedge clk); #1;
    chk("ignore_start_idle", 32'(bus.busy), 32'd0);

    // Reset while in MULT aborts the operation
    @(negedge clk);
    bus.start = 1'b1;
    bus.A = 32'hBFC00000;
    bus.B = 32'h40200000;
    @(posedge clk); #1;          // edge 0: UNPACK
    bus.start = 1'b0;
    @(posedge clk); #1;          // edge 1: MULT
    rst = 1'b1;
    #1;
    chk("abort_busy", 32'(bus.busy), 32'd0);
    chk("abort_Y",    bus.Y,         32'd0);
    @(negedge clk);
    rst = 1'b0;
    saw_rdy = 1'b0;
    repeat (8) begin
      @(posedge clk); #1;
      if (bus.ready === 1'b1) saw_rdy = 1'b1;
    end
    chk("abort_no_ready", 32'(saw_rdy), 32'd0);
    chk("abort_Y_held",   bus.Y,        32'd0);

    // Fresh operation after reset
    do_op(32'hBFC00000, 32'h40200000, y, lat, bok);
    chk("post_reset_Y",   y,        32'hC0700000);
    chk("post_reset_lat", 32'(lat), 32'd4);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule

// File: doc/multiplier_fp.md
# multiplier_fp

Multi-cycle IEEE-754 single-precision multiplier that forms each tap product (sample × coefficient) in the FIR datapath. It feeds the floating-point adder that accumulates the products. Its start/ready/busy handshake matches the adder's, so the sequencer drives both blocks identically. Subnormal inputs are flushed to zero, and the block produces canonical NaNs.

## Interface
No parameters.
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-high reset
- start  in  1  request; sampled only while busy=0
- A  in  32  multiplicand, IEEE-754 single
- B  in  32  multiplier, IEEE-754 single
- ready  out  1  one-cycle pulse; Y valid from this cycle
- busy  out  1  high while an operation is in flight
- Y  out  32  product; held until next result

## Operation
- Reset (async, rst=1): state IDLE; ready=0, busy=0, Y=0. Reset mid-operation aborts the operation: no ready pulse, and Y returns to 0.
- IDLE: on start=1, register A and B, set busy=1, go to UNPACK. start while busy=1 is ignored; the captured operands do not change.
- UNPACK: split each operand into sign, biased exponent and 24-bit mantissa with the hidden 1. Classify each operand:
  - zero: exp==0 (subnormals flush to zero);
  - inf: exp==255, man==0;
  - nan: exp==255, man!=0.
- MULT: compute sign = sA^sB and the 48-bit product mA*mB. Compute exponent as 10-bit signed eA+eB-127.
- NORM: if prod[47]=1, shift right 1 and increment exponent. Take the 23 fraction bits below the leading 1; the guard bit is next, and the sticky bit is the OR of the rest. Apply rounding (see Configuration). A mantissa carry-out renormalises and increments the exponent again.
- PACK, in priority order:
  1. any NaN, or inf×zero → 0x7FC00000.
  2. any inf → {sign, 0xFF, 0}.
  3. any zero → {sign, 0x00, 0}.
  4. exponent ≥255 → {sign, 0xFF, 0} (overflow to inf).
  5. exponent ≤0 → {sign, 0x00, 0} (underflow to signed zero).
  6. otherwise {sign, exp[7:0], frac}.
- On leaving PACK, write Y, set ready=1 and busy=0, and return to IDLE.

## Timing
- Start sampled at edge 0.
- busy=1 from after edge 0 through edge 4.
- UNPACK, MULT, NORM and PACK occupy edges 1-4.
- Y updates and ready=1 after edge 4; ready returns to 0 after edge 5.
- Latency: 4 cycles from start edge to ready. Throughput: one operation per 5 cycles.
- A start sampled in the ready cycle is accepted (busy=0). Back-to-back operations therefore carry no idle gap.
- start held high continuously restarts on every cycle that busy=0.
- Y does not change between ready pulses.
- ready and busy are never both 1.

## Configuration
- FP_MUL_RNE_EN defined: round to nearest, ties to even. Increment when guard & (sticky | lsb).
- FP_MUL_RNE_EN undefined: truncate toward zero. Guard and sticky are ignored, and no rounding adder is built.
- Latency is identical in both modes.

## Structure
- Shared package fp_pkg holds:
  - typedef fp32_t: packed {sign, exp[7:0], frac[22:0]};
  - constants FP_BIAS=127, FP_EXP_MAX=255, FP_QNAN=32'h7FC00000;
  - the state enum {IDLE, UNPACK, MULT, NORM, PACK}.
- The adder reuses fp32_t and FP_QNAN from fp_pkg.
- Sub-module fp_classify (combinational) takes one fp32_t and returns zero/inf/nan flags. It is instantiated twice.

## Test plan
- 0x40000000 × 0x40400000 (2×3) → Y=0x40C00000; ready exactly 4 cycles after the start edge; busy high for those 4 cycles.
- 0xBFC00000 × 0x40200000 (−1.5×2.5) → 0xC0700000. 0x80000000 × 0x40000000 → 0x80000000.
- 0x7F800000 × 0x00000000 → 0x7FC00000. 0x7F800000 × 0xC0000000 → 0xFF800000. 0x7FC00001 × 0x3F800000 → 0x7FC00000.
- 0x7F000000 × 0x7F000000 → 0x7F800000. 0x00800000 × 0x00800000 → 0x00000000. Subnormal 0x00000001 × 0x40000000 → 0x00000000.
- 0x3FC00001 × 0x3FC00001 → 0x40100002 with FP_MUL_RNE_EN, 0x40100001 without.
- Disturbance cases:
  - start pulsed again during busy with different operands → ignored; the first result is returned.
  - rst asserted in MULT → busy=0, Y=0, no ready pulse.
  - a new start after reset → normal result.
